hack_mem_arbiter: RTL
=====================

# hack_mem_arbiter

Shares the single-port Hack data RAM (32K×16, 1-cycle registered read) between the CPU data port and the VGA scanout fetcher. It also decodes the Hack memory map, so keyboard reads at 0x6000 never touch RAM. Sits between `hack_cpu`/video fetch and the RAM instance in the FPGA top level.

## Interface
- `MAX_VID_STREAK`, default 4: maximum consecutive video grants while a CPU request is pending; the next grant goes to the CPU.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request; held until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  15  CPU word address.
- `cpu_wdata`  in  16  write data.
- `cpu_gnt`  out  1  request accepted this cycle (combinational).
- `cpu_rvalid`  out  1  `cpu_rdata` is valid (registered).
- `cpu_rdata`  out  16  read data.
- `vid_req`  in  1  video fetch request.
- `vid_addr`  in  13  screen word offset, 0..8191.
- `vid_gnt`  out  1  video request accepted this cycle (combinational).
- `vid_rvalid`  out  1  `vid_rdata` is valid (registered).
- `vid_rdata`  out  16  screen word.
- `kbd_code`  in  16  current keyboard scan code.
- `mem_addr`  out  15  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  16  RAM write data.
- `mem_rdata`  in  16  RAM read data, valid the cycle after the address.

## Operation
- **Arbitration** (combinational, evaluated each cycle):
  - Video has priority over the CPU.
  - Exception: the CPU wins if `cpu_req` is set and `streak == MAX_VID_STREAK`.
  - At most one grant per cycle. No grants in any cycle where `reset` = 1.
- **Streak counter** (registered, width clog2(MAX_VID_STREAK+1)):
  - Increments when `vid_gnt` & `cpu_req`.
  - Clears when `cpu_gnt`, or when `cpu_req` = 0.
  - Saturates at `MAX_VID_STREAK`.
- **Video grant:**
  - `mem_addr` = 0x4000 + `vid_addr`; `mem_we` = 0.
- **CPU grant, address decode:**
  - `cpu_addr` < 0x6000: `mem_addr` = `cpu_addr`, `mem_we` = `cpu_we`, `mem_wdata` = `cpu_wdata`.
  - `cpu_addr` == 0x6000: no RAM access. A read returns `kbd_code`, sampled in the grant cycle. A write is dropped.
  - `cpu_addr` > 0x6000: no RAM access. A read returns 0. A write is dropped.
- **No grant:**
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Return path:**
  - A registered owner tag {NONE, CPU_RAM, CPU_KBD, CPU_ZERO, VID} records the grant.
  - Next cycle, route `mem_rdata` / the captured keyboard value / 0 to the owner, and pulse its rvalid for 1 cycle.
  - CPU writes produce no rvalid.
  - The non-owner's rdata holds its last value.

## Timing
- Grant cycle N → rvalid/rdata in cycle N+1. Read latency is 1 for RAM, keyboard and out-of-range reads.
- Writes commit at the end of cycle N.
- Back-to-back grants run at one per cycle. A read in N followed by a write in N+1 to the same address returns the old data in N+1.
- The requester deasserts or changes its request after seeing gnt. A request that stays high is treated as a new request.
- **Reset values:**
  - `cpu_rvalid` = `vid_rvalid` = 0.
  - `cpu_rdata` = `vid_rdata` = 0.
  - streak = 0; owner = NONE.
  - Grants and `mem_we` = 0 while `reset` = 1.
- **Reset mid-operation:** if reset is asserted in the cycle after a grant, the pending rvalid is suppressed.
- **Simultaneous requests:** `cpu_req` & `vid_req` with streak < MAX → video wins.
- **MAX_VID_STREAK = 0:** the CPU always wins ties.

## Structure
- **Package `hack_mem_pkg`:**
  - `SCREEN_BASE` = 15'h4000, `KBD_ADDR` = 15'h6000.
  - Owner-tag enum.
  - `RAM_WORDS` = 32768.
- **Sub-module `hack_mem_decode`:** combinational cpu_addr → {RAM, KBD, ZERO} decoder, reused by future MMIO blocks.
- **Arbiter body:** priority/streak logic and return mux, approx. 150–250 lines.

## Test plan
- **CPU-only traffic:** write 0x1234 to 0x0010, then read 0x0010 → `cpu_gnt` in both cycles, `cpu_rvalid` one cycle after the read grant, `cpu_rdata` = 0x1234.
- **Video-only traffic:** preload RAM[0x4005] = 0xBEEF; `vid_addr` = 5 → `mem_addr` = 0x4005, `vid_rvalid` next cycle with 0xBEEF; CPU outputs unchanged.
- **Contention, `MAX_VID_STREAK` = 4:** both requests held for 10 cycles → grant sequence V,V,V,V,C,V,V,V,V,C; streak returns to 0 after each C.
- **MMIO decode:**
  - `kbd_code` = 0x0041, CPU read 0x6000 → rdata 0x0041, `mem_we` = 0, RAM untouched.
  - Write 0x6000 → no RAM write.
  - Read 0x7FFF → rdata 0.
- **Reset during a read:** CPU read granted in cycle N, `reset` = 1 in cycle N+1 → no `cpu_rvalid`; all outputs at reset values and no grants while reset is high.
- **Read-after-write ordering:** read 0x0020 (old 0x0000) in N, write 0x5555 to 0x0020 in N+1, read in N+2 → rdata 0x0000 then 0x5555.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared constants and types for the Hack data-memory arbiter and its address decoder.
package hack_mem_pkg;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;
  localparam int unsigned RAM_WORDS   = 32768;

  // Which requester owns the read data returning in the next cycle.
  typedef enum logic [2:0] {
    OwnNone,
    OwnCpuRam,
    OwnCpuKbd,
    OwnCpuZero,
    OwnVid
  } owner_e;

endpackage

// File: rtl/hack_mem_decode.sv
// Hack memory-map decoder: classifies a CPU word address as RAM, keyboard, or unmapped.
module hack_mem_decode (
  input  logic [14:0] cpu_addr_i,
  output logic        is_ram_o,
  output logic        is_kbd_o,
  output logic        is_zero_o
);
  import hack_mem_pkg::*;

  always_comb begin
    is_ram_o  = (cpu_addr_i < KBD_ADDR);
    is_kbd_o  = (cpu_addr_i == KBD_ADDR);
    is_zero_o = (cpu_addr_i > KBD_ADDR);
  end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the single-port Hack data RAM between the CPU data port and video scanout,
// with a bounded video streak so a waiting CPU is never starved.
module hack_mem_arbiter #(
  parameter int unsigned MAX_VID_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [14:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic [15:0] cpu_rdata_o,
  input  logic        vid_req_i,
  input  logic [12:0] vid_addr_i,
  output logic        vid_gnt_o,
  output logic        vid_rvalid_o,
  output logic [15:0] vid_rdata_o,
  input  logic [15:0] kbd_code_i,
  output logic [14:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);
  import hack_mem_pkg::*;

  // A zero limit still needs a one-bit counter that simply stays at zero.
  localparam int unsigned StreakW = (MAX_VID_STREAK > 0) ? $clog2(MAX_VID_STREAK + 1) : 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_VID_STREAK);

  logic [StreakW-1:0] streak_q, streak_d;
  owner_e             owner_q, owner_d;
  logic [15:0]        kbd_q, kbd_d;
  logic [15:0]        cpu_rdata_q, vid_rdata_q;
  logic               cpu_wins, cpu_gnt, vid_gnt;
  logic               is_ram, is_kbd, is_zero;

  hack_mem_decode u_decode (
    .cpu_addr_i (cpu_addr_i),
    .is_ram_o   (is_ram),
    .is_kbd_o   (is_kbd),
    .is_zero_o  (is_zero)
  );

  always_comb begin
    cpu_wins = cpu_req_i && (streak_q == StreakMax);
    vid_gnt  = !reset_i && vid_req_i && !cpu_wins;
    cpu_gnt  = !reset_i && cpu_req_i && !vid_gnt;

    streak_d = streak_q;
    if (cpu_gnt || !cpu_req_i) begin
      streak_d = '0;
    end else if (vid_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  assign cpu_gnt_o = cpu_gnt;
  assign vid_gnt_o = vid_gnt;

  // Memory-side request and owner tag for the data returning next cycle.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    owner_d     = OwnNone;
    kbd_d       = kbd_q;
    if (vid_gnt) begin
      mem_addr_o = SCREEN_BASE + {2'b00, vid_addr_i};
      owner_d    = OwnVid;
    end else if (cpu_gnt) begin
      if (is_ram) begin
        mem_addr_o  = cpu_addr_i;
        mem_we_o    = cpu_we_i;
        mem_wdata_o = cpu_wdata_i;
        if (!cpu_we_i) owner_d = OwnCpuRam;
      end else if (is_kbd) begin
        if (!cpu_we_i) begin
          owner_d = OwnCpuKbd;
          kbd_d   = kbd_code_i;
        end
      end else if (is_zero && !cpu_we_i) begin
        owner_d = OwnCpuZero;
      end
    end
  end

  // Return path; the non-owner keeps presenting its last word.
  always_comb begin
    cpu_rvalid_o = 1'b0;
    vid_rvalid_o = 1'b0;
    cpu_rdata_o  = cpu_rdata_q;
    vid_rdata_o  = vid_rdata_q;
    if (reset_i) begin
      cpu_rdata_o = '0;
      vid_rdata_o = '0;
    end else begin
      unique case (owner_q)
        OwnCpuRam: begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = mem_rdata_i;
        end
        OwnCpuKbd: begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = kbd_q;
        end
        OwnCpuZero: begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = '0;
        end
        OwnVid: begin
          vid_rvalid_o = 1'b1;
          vid_rdata_o  = mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_q    <= '0;
      owner_q     <= OwnNone;
      kbd_q       <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      streak_q    <= streak_d;
      owner_q     <= owner_d;
      kbd_q       <= kbd_d;
      cpu_rdata_q <= cpu_rdata_o;
      vid_rdata_q <= vid_rdata_o;
    end
  end

endmodule
